// File: rtl/pwm_multi_pkg.sv
// Shared constants and saturating duty arithmetic for the multi-channel PWM controller.
package pwm_multi_pkg;

    localparam int unsigned DEF_CHANNELS  = 4;
    localparam int unsigned DEF_CNT_W     = 8;
    localparam int unsigned DEF_PERIOD    = 100;
    localparam int unsigned DEF_STEP      = 10;
    localparam int unsigned DEF_INIT_DUTY = 50;
    localparam int unsigned DEF_DEB_DIV   = 250000;
    localparam int unsigned DEF_DEB_W     = 18;

    // 32-bit arithmetic is wider than any duty register, so the sum cannot wrap.
    function automatic int unsigned clamp_duty(input int unsigned cur,
                                               input int unsigned step,
                                               input logic        inc,
                                               input int unsigned lim);
        if (inc)
            return (cur + step > lim) ? lim : cur + step;
        else
            return (cur < step) ? 0 : cur - step;
    endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// Button synchroniser, tick-sampled debounce and rising-edge press detect.
module pwm_btn_debounce (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic press
);

    logic sync1;
    logic sync2;
    logic s1;
    logic s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            s1    <= 1'b0;
            s2    <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (tick) begin
                s1 <= sync2;
                s2 <= s1;
            end
        end
    end

    assign press = s1 & ~s2 & tick;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator with shared period counter and button-adjusted shadow duties.
module pwm_multi_ctrl
    import pwm_multi_pkg::*;
#(
    parameter int unsigned CHANNELS  = DEF_CHANNELS,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned PERIOD    = DEF_PERIOD,
    parameter int unsigned STEP      = DEF_STEP,
    parameter int unsigned INIT_DUTY = DEF_INIT_DUTY,
    parameter int unsigned DEB_DIV   = DEF_DEB_DIV,
    parameter int unsigned DEB_W     = DEF_DEB_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                btn_inc,
    input  logic                btn_dec,
    input  logic [2:0]          sel,
    input  logic [CHANNELS-1:0] pol,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CNT_W-1:0]    duty_rd,
    output logic                period_start
);

    logic [DEB_W-1:0] div;
    logic             tick;
    logic             press_inc;
    logic             press_dec;
    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic [CNT_W-1:0] shadow [CHANNELS];
    logic [CNT_W-1:0] active [CHANNELS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div <= '0;
        else if (tick)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    assign tick = (div == DEB_W'(DEB_DIV - 1));

    pwm_btn_debounce u_deb_inc (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .btn   (btn_inc),
        .press (press_inc)
    );

    pwm_btn_debounce u_deb_dec (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .btn   (btn_dec),
        .press (press_dec)
    );

    // Simultaneous inc and dec cancel; out-of-range sel matches no channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < CHANNELS; ch++)
                shadow[ch] <= CNT_W'(INIT_DUTY);
        end else if (press_inc ^ press_dec) begin
            for (int ch = 0; ch < CHANNELS; ch++)
                if (sel == 3'(ch))
                    shadow[ch] <= CNT_W'(clamp_duty(32'(shadow[ch]), STEP, press_inc, PERIOD));
        end
    end

    assign wrap = (cnt == CNT_W'(PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!en || wrap)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Active duty only changes at a period boundary, or freely while stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < CHANNELS; ch++)
                active[ch] <= CNT_W'(INIT_DUTY);
        end else if (!en || wrap) begin
            for (int ch = 0; ch < CHANNELS; ch++)
                active[ch] <= shadow[ch];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++)
                pwm_out[ch] <= ((cnt < active[ch]) & en) ^ pol[ch];
            period_start <= en & (cnt == '0);
        end
    end

    always_comb begin
        duty_rd = '0;
        for (int ch = 0; ch < CHANNELS; ch++)
            if (sel == 3'(ch))
                duty_rd = shadow[ch];
    end

endmodule
